// File: rtl/xm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : xm_stage
//  Purpose  : Execute->Memory boundary stage. Resolves bne/blt, optionally
//             rewrites overflowing arithmetic into an rstatus ($r30) write,
//             and buffers results in a 2-entry skid FIFO with a valid/ready
//             handshake toward the memory stage.
//  Options  : XM_OVF_EXCEPTION_EN - when defined, overflow on add/addi/sub
//             replaces the entry with rd=RSTAT_REG, result=code, wren=1.
//  Revision : 1.0 - initial release
// ============================================================================
module xm_stage #(
  parameter int DEPTH     = 2,
  parameter int RSTAT_REG = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_opcode,
  input  logic [4:0]  in_aluop,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_result,
  input  logic [31:0] in_stdata,
  input  logic        in_overflow,
  input  logic        in_ne,
  input  logic        in_lt,
  input  logic [31:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic [31:0] out_stdata,
  output logic        out_wren,
  output logic        br_taken,
  output logic [31:0] br_target
);

  localparam logic [1:0] c_FULL     = 2'(DEPTH);
  localparam logic [4:0] c_RSTAT    = 5'(RSTAT_REG);
  localparam logic [4:0] c_OP_RTYPE = 5'b00000;
  localparam logic [4:0] c_OP_BNE   = 5'b00010;
  localparam logic [4:0] c_OP_ADDI  = 5'b00101;
  localparam logic [4:0] c_OP_BLT   = 5'b00110;
  localparam logic [4:0] c_OP_LW    = 5'b01000;
  localparam logic [4:0] c_ALU_ADD  = 5'b00000;
  localparam logic [4:0] c_ALU_SUB  = 5'b00001;

  // FIFO bookkeeping
  logic [1:0]  r_count;
  logic        r_rd_ptr;
  logic        r_wr_ptr;

  // FIFO storage (not reset; outputs are gated while empty)
  logic [4:0]  r_mem_opcode [2];
  logic [4:0]  r_mem_rd     [2];
  logic [31:0] r_mem_result [2];
  logic [31:0] r_mem_stdata [2];
  logic        r_mem_wren   [2];

  logic        r_br_taken;
  logic [31:0] r_br_target;

  logic        w_push;
  logic        w_pop;
  logic        w_is_branch;
  logic        w_br_cond;
  logic        w_wren_base;
  logic [4:0]  w_ent_rd;
  logic [31:0] w_ent_result;
  logic        w_ent_wren;

  // Handshake: in_ready depends only on registered occupancy
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  // Decode the incoming instruction: regfile write enable and branch condition
  always_comb begin
    w_wren_base = (in_opcode == c_OP_RTYPE) || (in_opcode == c_OP_ADDI) ||
                  (in_opcode == c_OP_LW);
    w_is_branch = (in_opcode == c_OP_BNE) || (in_opcode == c_OP_BLT);
    w_br_cond   = ((in_opcode == c_OP_BNE) && in_ne) ||
                  ((in_opcode == c_OP_BLT) && in_lt);
  end

`ifdef XM_OVF_EXCEPTION_EN
  logic [1:0] w_ovf_code;
  logic       w_exc;

  // Map overflowing add/addi/sub to an rstatus code; the ALU result is dropped
  always_comb begin
    w_ovf_code = 2'd0;
    if (in_opcode == c_OP_RTYPE && in_aluop == c_ALU_ADD)
      w_ovf_code = 2'd1;
    else if (in_opcode == c_OP_ADDI)
      w_ovf_code = 2'd2;
    else if (in_opcode == c_OP_RTYPE && in_aluop == c_ALU_SUB)
      w_ovf_code = 2'd3;
    w_exc        = in_overflow && (w_ovf_code != 2'd0);
    w_ent_rd     = w_exc ? c_RSTAT : in_rd;
    w_ent_result = w_exc ? {30'd0, w_ovf_code} : in_result;
    w_ent_wren   = w_exc | w_wren_base;
  end
`else
  // Overflow is ignored: fields pass through untouched
  logic w_unused;
  assign w_unused = ^{in_overflow, in_aluop, c_RSTAT, c_ALU_ADD, c_ALU_SUB};

  // Entry fields pass straight through
  always_comb begin
    w_ent_rd     = in_rd;
    w_ent_result = in_result;
    w_ent_wren   = w_wren_base;
  end
`endif

  // Occupancy and pointers; flush outranks push/pop
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_count  <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write the accepted entry into the slot at the write pointer
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_mem_opcode[r_wr_ptr] <= in_opcode;
      r_mem_rd[r_wr_ptr]     <= w_ent_rd;
      r_mem_result[r_wr_ptr] <= w_ent_result;
      r_mem_stdata[r_wr_ptr] <= in_stdata;
      r_mem_wren[r_wr_ptr]   <= w_ent_wren;
    end
  end

  // Branch resolution: one-cycle pulse on the push of a taken bne/blt
  always_ff @(posedge clock) begin
    if (reset) begin
      r_br_taken  <= 1'b0;
      r_br_target <= 32'd0;
    end else if (flush) begin
      r_br_taken  <= 1'b0;
    end else begin
      r_br_taken <= w_push & w_br_cond;
      if (w_push && w_is_branch) r_br_target <= in_target;
    end
  end

  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;

  // Head-of-FIFO outputs, forced to zero while empty
  always_comb begin
    out_opcode = 5'd0;
    out_rd     = 5'd0;
    out_result = 32'd0;
    out_stdata = 32'd0;
    out_wren   = 1'b0;
    if (out_valid) begin
      out_opcode = r_mem_opcode[r_rd_ptr];
      out_rd     = r_mem_rd[r_rd_ptr];
      out_result = r_mem_result[r_rd_ptr];
      out_stdata = r_mem_stdata[r_rd_ptr];
      out_wren   = r_mem_wren[r_rd_ptr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xm_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xm_stage
//  Purpose  : Self-checking bench for xm_stage: directed scenarios followed by
//             randomized traffic compared against a queue-based model.
//  Options  : XM_OVF_EXCEPTION_EN - must match the RTL build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xm_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [4:0]  in_opcode, in_aluop, in_rd;
  logic [31:0] in_result, in_stdata, in_target;
  logic        in_overflow, in_ne, in_lt;
  logic        out_valid, out_ready;
  logic [4:0]  out_opcode, out_rd;
  logic [31:0] out_result, out_stdata;
  logic        out_wren, br_taken;
  logic [31:0] br_target;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] result;
    logic [31:0] stdata;
    logic        wren;
  } entry_t;

  entry_t      m_q[$];
  logic        m_br;
  logic [31:0] m_tgt;

  xm_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_aluop(in_aluop), .in_rd(in_rd),
    .in_result(in_result), .in_stdata(in_stdata),
    .in_overflow(in_overflow), .in_ne(in_ne), .in_lt(in_lt),
    .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd),
    .out_result(out_result), .out_stdata(out_stdata),
    .out_wren(out_wren), .br_taken(br_taken), .br_target(br_target)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entry the memory stage should see for the current inputs
  function automatic entry_t make_entry();
    entry_t e;
    int code;
    e.opcode = in_opcode;
    e.rd     = in_rd;
    e.result = in_result;
    e.stdata = in_stdata;
    e.wren   = (in_opcode == 5'd0) || (in_opcode == 5'd5) || (in_opcode == 5'd8);
`ifdef XM_OVF_EXCEPTION_EN
    code = 0;
    if (in_opcode == 5'd0 && in_aluop == 5'd0) code = 1;
    else if (in_opcode == 5'd5)                code = 2;
    else if (in_opcode == 5'd0 && in_aluop == 5'd1) code = 3;
    if (in_overflow && code != 0) begin
      e.rd     = 5'd30;
      e.result = code;
      e.wren   = 1'b1;
    end
`else
    code = 0;
`endif
    return e;
  endfunction

  // Advance the model by one clock edge using the inputs held across it
  task automatic model_edge();
    bit push, pop;
    push = in_valid && (m_q.size() != 2) && !flush;
    pop  = (m_q.size() != 0) && out_ready;
    if (reset) begin
      m_q.delete();
      m_br  = 1'b0;
      m_tgt = 32'd0;
    end else if (flush) begin
      m_q.delete();
      m_br = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back(make_entry());
      m_br = push && ((in_opcode == 5'd2 && in_ne) || (in_opcode == 5'd6 && in_lt));
      if (push && (in_opcode == 5'd2 || in_opcode == 5'd6)) m_tgt = in_target;
    end
  endtask

  task automatic compare_all();
    entry_t h;
    h = '{5'd0, 5'd0, 32'd0, 32'd0, 1'b0};
    if (m_q.size() != 0) h = m_q[0];
    check_eq("in_ready",   32'(in_ready),   32'(m_q.size() != 2));
    check_eq("out_valid",  32'(out_valid),  32'(m_q.size() != 0));
    check_eq("out_opcode", 32'(out_opcode), 32'(h.opcode));
    check_eq("out_rd",     32'(out_rd),     32'(h.rd));
    check_eq("out_result", out_result,      h.result);
    check_eq("out_stdata", out_stdata,      h.stdata);
    check_eq("out_wren",   32'(out_wren),   32'(h.wren));
    check_eq("br_taken",   32'(br_taken),   32'(m_br));
    check_eq("br_target",  br_target,       m_tgt);
  endtask

  // One clock: inputs already set; update model at the edge, compare mid-cycle
  task automatic cycle();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    compare_all();
  endtask

  task automatic set_in(input bit v, input logic [4:0] op, input logic [4:0] aop,
                        input logic [4:0] rd, input logic [31:0] res);
    in_valid  = v;
    in_opcode = op;
    in_aluop  = aop;
    in_rd     = rd;
    in_result = res;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_stdata = 32'd0; in_target = 32'd0;
    in_overflow = 1'b0; in_ne = 1'b0; in_lt = 1'b0;
    m_br = 1'b0; m_tgt = 32'd0;

    // Reset for two cycles
    cycle(); cycle();
    check_eq("rst_out_valid",  32'(out_valid), 32'd0);
    check_eq("rst_in_ready",   32'(in_ready),  32'd1);
    check_eq("rst_br_taken",   32'(br_taken),  32'd0);
    check_eq("rst_out_result", out_result,     32'd0);
    reset = 1'b0;

    // add 0x7FFFFFFF+1 overflowing into rd=5
    set_in(1'b1, 5'd0, 5'd0, 5'd5, 32'h8000_0000);
    in_overflow = 1'b1;
    cycle();
`ifdef XM_OVF_EXCEPTION_EN
    check_eq("ovf_rd",     32'(out_rd),   32'd30);
    check_eq("ovf_result", out_result,    32'd1);
`else
    check_eq("ovf_rd",     32'(out_rd),   32'd5);
    check_eq("ovf_result", out_result,    32'h8000_0000);
`endif
    check_eq("ovf_wren",   32'(out_wren), 32'd1);
    in_overflow = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    check_eq("drain_empty", 32'(out_valid), 32'd0);

    // Fill with out_ready low, then drain in order
    out_ready = 1'b0;
    set_in(1'b1, 5'd0, 5'd2, 5'd1, 32'h11); cycle();
    set_in(1'b1, 5'd0, 5'd2, 5'd2, 32'h22); cycle();
    check_eq("full_in_ready", 32'(in_ready), 32'd0);
    set_in(1'b1, 5'd0, 5'd2, 5'd3, 32'h33); cycle();
    check_eq("full_head_rd1", 32'(out_rd), 32'd1);
    out_ready = 1'b1; cycle();
    check_eq("drain_head_rd2", 32'(out_rd),   32'd2);
    check_eq("space_in_ready", 32'(in_ready), 32'd1);
    cycle();   // push rd3 and pop rd2 on the same edge
    check_eq("pp_head_rd3",   32'(out_rd),    32'd3);
    check_eq("pp_valid",      32'(out_valid), 32'd1);
    check_eq("pp_count1",     32'(in_ready),  32'd1);
    in_valid = 1'b0; cycle();

    // bne taken, then idle, then blt not taken
    set_in(1'b1, 5'd2, 5'd0, 5'd9, 32'd0);
    in_ne = 1'b1; in_target = 32'h40;
    cycle();
    check_eq("bne_taken",  32'(br_taken), 32'd1);
    check_eq("bne_target", br_target,     32'h40);
    check_eq("bne_wren",   32'(out_wren), 32'd0);
    in_valid = 1'b0; in_ne = 1'b0; cycle();
    check_eq("bne_pulse_end", 32'(br_taken), 32'd0);
    set_in(1'b1, 5'd6, 5'd0, 5'd9, 32'd0);
    in_lt = 1'b0; in_target = 32'h80;
    cycle();
    check_eq("blt_not_taken", 32'(br_taken), 32'd0);
    in_valid = 1'b0; cycle();

    // Fill to 2, then flush while presenting a new instruction
    out_ready = 1'b0;
    set_in(1'b1, 5'd8, 5'd0, 5'd4, 32'h44); cycle(); cycle();
    set_in(1'b1, 5'd5, 5'd0, 5'd6, 32'h66); flush = 1'b1; cycle();
    check_eq("flush_valid", 32'(out_valid), 32'd0);
    check_eq("flush_ready", 32'(in_ready),  32'd1);
    flush = 1'b0; in_valid = 1'b0; cycle();
    check_eq("flush_no_capture", 32'(out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 99) < 1);
      flush       = ($urandom_range(0, 99) < 3);
      in_valid    = ($urandom_range(0, 99) < 70);
      out_ready   = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 4))
          0: in_opcode = 5'd0;
          1: in_opcode = 5'd5;
          2: in_opcode = 5'd8;
          3: in_opcode = 5'd2;
          default: in_opcode = 5'd6;
        endcase
      end else begin
        in_opcode = 5'($urandom_range(0, 31));
      end
      in_aluop    = 5'($urandom_range(0, 3));
      in_rd       = 5'($urandom);
      in_result   = $urandom;
      in_stdata   = $urandom;
      in_target   = $urandom;
      in_overflow = ($urandom_range(0, 99) < 30);
      in_ne       = 1'($urandom);
      in_lt       = 1'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
